// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-vector sweep controller: drives every NIN-bit vector to a DUT,
// records each single-bit response, and compacts the responses into a 16-bit MISR signature.
module vector_sweep_ctrl #(
    parameter int unsigned NIN    = 3,
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          golden,
    input  logic                 dut_out,
    output logic [NIN-1:0]       vec_out,
    output logic                 vec_valid,
    output logic                 cap_valid,
    output logic                 busy,
    output logic                 done,
    output logic [2**NIN-1:0]    resp_map,
    output logic [15:0]          signature,
    output logic                 match,
    output logic                 mismatch
);

    localparam int unsigned  NVEC       = 2**NIN;
    localparam logic [NIN:0] LAST_IDX   = (NIN+1)'(NVEC - 1);
    localparam logic [3:0]   SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NIN:0]       idx_q, idx_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [NVEC-1:0]    resp_q, resp_d;
    logic [15:0]        sig_q, sig_d;
    logic               fb;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            sig_q   <= sig_d;
        end
    end

    assign fb = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        sig_d   = sig_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    resp_d  = '0;
                    sig_d   = SEED;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (SETTLE == 0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = SETTLE_CNT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                // An abort here discards the in-flight response rather than capturing it.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    resp_d[idx_q[NIN-1:0]] = dut_out;
                    sig_d = {sig_q[14:0], fb ^ dut_out};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    resp_d  = '0;
                    sig_d   = SEED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
    assign vec_valid = busy;
    assign cap_valid = (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    // Vector is derived from idx, which only moves on the edge entering APPLY.
    assign vec_out   = busy ? idx_q[NIN-1:0] : '0;
    assign resp_map  = resp_q;
    assign signature = sig_q;
    assign match     = done && (sig_q == golden);
    assign mismatch  = done && (sig_q != golden);

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Self-checking bench: two controllers (SETTLE=1 and SETTLE=0) sweep a truth-table DUT model;
// results are compared against a spec-level model of the response map and MISR signature.
module tb_vector_sweep_ctrl;

    logic        CK = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] golden;
    logic [7:0]  tt_r;

    logic [2:0]  vec1, vec0;
    logic        vv1, cv1, busy1, done1, match1, mm1, dout1;
    logic        vv0, cv0, busy0, done0, match0, mm0, dout0;
    logic [7:0]  resp1, resp0;
    logic [15:0] sig1, sig0;

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    assign dout1 = tt_r[vec1];
    assign dout0 = tt_r[vec0];

    vector_sweep_ctrl #(.NIN(3), .SETTLE(1), .SEED(16'hFFFF)) u_dut (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .golden(golden),
        .dut_out(dout1), .vec_out(vec1), .vec_valid(vv1), .cap_valid(cv1),
        .busy(busy1), .done(done1), .resp_map(resp1), .signature(sig1),
        .match(match1), .mismatch(mm1)
    );

    vector_sweep_ctrl #(.NIN(3), .SETTLE(0), .SEED(16'hFFFF)) u_dut0 (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .golden(golden),
        .dut_out(dout0), .vec_out(vec0), .vec_valid(vv0), .cap_valid(cv0),
        .busy(busy0), .done(done0), .resp_map(resp0), .signature(sig0),
        .match(match0), .mismatch(mm0)
    );

    // Signature after compacting the responses of vectors 0..n-1 of truth table tt.
    function automatic logic [15:0] misr_model(input logic [7:0] tt, input int n);
        logic [15:0] s;
        logic        f;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            f = s[15] ^ s[13] ^ s[12] ^ s[10];
            s = {s[14:0], f ^ tt[i]};
        end
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; golden = 16'h0000; tt_r = 8'h00;
        @(negedge CK);
        checks++;
        if ({busy1, vv1, cv1, done1, match1, mm1} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {busy1, vv1, cv1, done1, match1, mm1});
        end
        checks++;
        if (vec1 !== 3'd0 || resp1 !== 8'h00) begin
            errors++; $display("FAIL reset_vec_resp: got vec=%0d resp=%h want 0/00", vec1, resp1);
        end
        checks++;
        if (sig1 !== 16'hFFFF || sig0 !== 16'hFFFF) begin
            errors++; $display("FAIL reset_sig: got %h/%h want FFFF", sig1, sig0);
        end
        reset = 1'b1;
        repeat (3) @(negedge CK);
        checks++;
        if ({busy1, done1, busy0, done0} !== 4'b0 || vec1 !== 3'd0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b done=%b vec=%0d want idle", busy1, done1, vec1);
        end
    endtask

    // Full SETTLE=1 sweep; start is re-pulsed at cycle 'poke' (negative = never).
    task automatic test_sweep(input logic [7:0] tt, input logic flip, input int poke);
        logic [15:0] exp_sig;
        tt_r    = tt;
        exp_sig = misr_model(tt, 8);
        golden  = exp_sig ^ {15'b0, flip};
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        checks++;
        if (sig1 !== 16'hFFFF || resp1 !== 8'h00) begin
            errors++; $display("FAIL sweep_init: sig=%h resp=%h want FFFF/00", sig1, resp1);
        end
        for (int c = 0; c < 24; c++) begin
            start = (c == poke);
            checks++;
            if ({busy1, vv1, done1} !== 3'b110 || vec1 !== 3'(c / 3) || cv1 !== (c % 3 == 2)) begin
                errors++;
                $display("FAIL sweep_cycle%0d: busy=%b vv=%b done=%b vec=%0d cap=%b want 1 1 0 %0d %b",
                         c, busy1, vv1, done1, vec1, cv1, c / 3, (c % 3 == 2));
            end
            @(negedge CK);
        end
        start = 1'b0;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL sweep_done: done=%b busy=%b want 1/0", done1, busy1);
        end
        checks++;
        if (resp1 !== tt) begin
            errors++; $display("FAIL sweep_resp: got %b want %b", resp1, tt);
        end
        checks++;
        if (sig1 !== exp_sig) begin
            errors++; $display("FAIL sweep_sig: got %h want %h", sig1, exp_sig);
        end
        checks++;
        if (match1 !== !flip || mm1 !== flip) begin
            errors++; $display("FAIL sweep_match: match=%b mismatch=%b want %b/%b", match1, mm1, !flip, flip);
        end
        checks++;
        if (done0 !== 1'b1 || resp0 !== tt) begin
            errors++; $display("FAIL sweep_settle0_resp: done=%b resp=%b want 1/%b", done0, resp0, tt);
        end
    endtask

    task automatic test_and3();
        test_sweep(8'b1000_0000, 1'b0, -1);
    endtask

    task automatic test_done_hold();
        repeat (3) begin
            @(negedge CK);
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || vec1 !== 3'd0) begin
                errors++; $display("FAIL done_hold: done=%b busy=%b vec=%0d want 1/0/0", done1, busy1, vec1);
            end
        end
    endtask

    task automatic test_restart_from_done();
        test_sweep(8'b1000_0000, 1'b1, -1);
    endtask

    task automatic test_start_in_wait();
        test_sweep(8'($urandom), 1'b0, 1);
    endtask

    task automatic test_abort();
        logic [7:0] tt;
        tt     = 8'($urandom);
        tt_r   = tt;
        golden = 16'($urandom);
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        repeat (9) @(negedge CK);
        checks++;
        if (busy1 !== 1'b1 || vec1 !== 3'd3) begin
            errors++; $display("FAIL abort_pre: busy=%b vec=%0d want 1/3", busy1, vec1);
        end
        abort = 1'b1;
        @(negedge CK); abort = 1'b0;
        checks++;
        if ({busy1, done1, vv1, cv1} !== 4'b0 || vec1 !== 3'd0) begin
            errors++; $display("FAIL abort_idle: busy=%b done=%b vec=%0d want 0/0/0", busy1, done1, vec1);
        end
        checks++;
        if (resp1 !== {5'b0, tt[2:0]}) begin
            errors++; $display("FAIL abort_resp: got %b want %b", resp1, {5'b0, tt[2:0]});
        end
        checks++;
        if (sig1 !== misr_model(tt, 3)) begin
            errors++; $display("FAIL abort_sig: got %h want %h", sig1, misr_model(tt, 3));
        end
        repeat (2) @(negedge CK);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL abort_stays_idle: busy=%b done=%b want 0/0", busy1, done1);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] tt;
        tt   = 8'($urandom) | 8'h01;
        tt_r = tt;
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        repeat (4) @(negedge CK);
        checks++;
        if (busy1 !== 1'b1 || vec1 !== 3'd1 || cv1 !== 1'b0) begin
            errors++; $display("FAIL areset_pre: busy=%b vec=%0d cap=%b want 1/1/0", busy1, vec1, cv1);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy1, vv1, cv1, done1, match1, mm1} !== 6'b0 || vec1 !== 3'd0) begin
            errors++; $display("FAIL areset_flags: flags=%b vec=%0d want 0/0", {busy1, vv1, cv1, done1, match1, mm1}, vec1);
        end
        checks++;
        if (resp1 !== 8'h00 || sig1 !== 16'hFFFF) begin
            errors++; $display("FAIL areset_state: resp=%h sig=%h want 00/FFFF", resp1, sig1);
        end
        @(negedge CK); reset = 1'b1;
        test_sweep(tt, 1'b0, -1);
    endtask

    task automatic test_settle0_xor();
        int n;
        tt_r   = 8'b1001_0110;
        golden = misr_model(8'b1001_0110, 8);
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            @(negedge CK);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL settle0_len: got %0d cycles want 16", n);
        end
        checks++;
        if (resp0 !== 8'b1001_0110) begin
            errors++; $display("FAIL settle0_resp: got %b want 10010110", resp0);
        end
        checks++;
        if (sig0 !== misr_model(8'b1001_0110, 8) || match0 !== 1'b1 || mm0 !== 1'b0) begin
            errors++; $display("FAIL settle0_sig: got %h m=%b mm=%b want %h 1 0", sig0, match0, mm0,
                               misr_model(8'b1001_0110, 8));
        end
        repeat (10) @(negedge CK);
    endtask

    task automatic test_random_sweeps();
        for (int k = 0; k < 4; k++) begin
            test_sweep(8'($urandom), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_and3();
        test_done_hold();
        test_restart_from_done();
        test_start_in_wait();
        test_abort();
        test_async_reset();
        test_settle0_xor();
        test_random_sweeps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_sweep_ctrl.md
VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 Parameter NIN, 3, DUT primary-input count; legal range 1..8.
REQ-002 Parameter SETTLE, 1, wait cycles between vector apply and response capture; legal range 0..15.
REQ-003 Parameter SEED, 16'hFFFF, signature register reset/start value.
REQ-004 CK  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 start  input  1  begin exhaustive sweep; sampled in IDLE or DONE only.
REQ-007 abort  input  1  terminate sweep; sampled in every state.
REQ-008 golden  input  16  expected final signature; sampled only in DONE.
REQ-009 dut_out  input  1  DUT single-bit response.
REQ-010 vec_out  output  NIN  vector driven to DUT; value equals sweep index, vec_out[NIN-1] is MSB.
REQ-011 vec_valid  output  1  high in APPLY, WAIT and CAPTURE.
REQ-012 cap_valid  output  1  one-cycle pulse in CAPTURE.
REQ-013 busy  output  1  high in APPLY, WAIT and CAPTURE.
REQ-014 done  output  1  high throughout DONE.
REQ-015 resp_map  output  2**NIN  bit i = dut_out captured for vector i.
REQ-016 signature  output  16  MISR compaction of captured responses.
REQ-017 match  output  1  in DONE: signature == golden; 0 elsewhere.
REQ-018 mismatch  output  1  in DONE: signature != golden; 0 elsewhere.

Function
REQ-019 FSM states SHALL be IDLE, APPLY, WAIT, CAPTURE, DONE.
REQ-020 IDLE: start=1 and abort=0 -> APPLY; idx=0, resp_map cleared, signature=SEED.
REQ-021 APPLY lasts 1 cycle -> WAIT with settle counter loaded to SETTLE; SETTLE=0 -> CAPTURE directly.
REQ-022 WAIT: counter decrements each cycle; on the cycle it reaches 0 -> CAPTURE; WAIT lasts exactly SETTLE cycles.
REQ-023 CAPTURE lasts 1 cycle: resp_map[idx] <= dut_out; signature updated; cap_valid=1.
REQ-024 CAPTURE with idx == 2**NIN-1 -> DONE; otherwise idx+1 -> APPLY.
REQ-025 vec_out SHALL be stable from APPLY through CAPTURE of a vector; it changes only on the APPLY entry edge.
REQ-026 Cycles per vector SHALL be 2+SETTLE; sweep length 2**NIN*(2+SETTLE) cycles from the first APPLY cycle to the first DONE cycle.
REQ-027 MISR update: fb = sig[15]^sig[13]^sig[12]^sig[10]; sig <= {sig[14:0], fb^dut_out}.
REQ-028 DONE persists until start or abort; start=1 in DONE restarts per REQ-020.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle; resp_map and signature retain partial values; vec_out <= 0.
REQ-030 abort and start asserted together: abort SHALL win.
REQ-031 start in APPLY, WAIT or CAPTURE SHALL be ignored.
REQ-032 idx SHALL be NIN+1 bits wide so the terminal compare never wraps; no sweep index beyond 2**NIN-1 is ever driven.
REQ-033 In IDLE: vec_out=0, vec_valid=0, cap_valid=0.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, idx=0, vec_out=0, resp_map=0, signature=SEED, and all 1-bit outputs to 0, including mid-sweep.
REQ-035 After reset deasserts, the block SHALL take no action until start is sampled high.

Verification
REQ-036 NIN=3, SETTLE=1, DUT model = AND3, start pulse -> vec_out sequence 0..7, 3 cycles each; done high 24 cycles after the first APPLY cycle; resp_map=8'b1000_0000.
REQ-037 Same sweep, golden = reference-model MISR value -> match=1, mismatch=0; golden with bit 0 flipped -> match=0, mismatch=1.
REQ-038 abort on the 10th busy cycle -> IDLE next cycle, busy=0, done=0, vec_out=0, resp_map bits 0..2 hold captured values.
REQ-039 reset=0 asserted mid-WAIT, asynchronous to CK -> all outputs at reset values before the next CK edge; a new start gives a full, correct sweep.
REQ-040 start asserted in WAIT -> ignored, sweep completes unchanged; start in DONE -> new sweep from vector 0 with signature reseeded to SEED.
REQ-041 SETTLE=0, NIN=3, DUT = XOR3 -> 16-cycle sweep, resp_map=8'b1001_0110.
